// File: rtl/shared_unit_arbiter.sv
// rtl/shared_unit_arbiter.sv - round-robin arbiter sharing one multi-cycle unit among four requesters
// Optional hung-operation watchdog enabled by defining ARB_WATCHDOG_EN.
module shared_unit_arbiter #(
    parameter int SIZE    = 96,
    parameter int TIMEOUT = 255
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic [3:0]        iRequest,
    input  logic [4*SIZE-1:0] iOperand,
    output logic [3:0]        oGrant,
    output logic              oUnitStart,
    output logic [SIZE-1:0]   oUnitOperand,
    input  logic              iUnitDone,
    output logic [3:0]        oDone,
    output logic              oBusy,
    output logic              oTimeout
);

    typedef enum logic [1:0] {IDLE, START, BUSY, RELEASE} state_t;

    state_t          state;
    state_t          state_next;
    logic [3:0]      ptr;
    logic [3:0]      grant;
    logic [SIZE-1:0] operand;
    logic [1:0]      ptr_idx;
    logic [1:0]      scan_idx;
    logic [1:0]      win_idx;
    logic [3:0]      winner;
    logic            found;
    logic            expire;

    always_comb begin
        case (ptr)
            4'b0010: ptr_idx = 2'd1;
            4'b0100: ptr_idx = 2'd2;
            4'b1000: ptr_idx = 2'd3;
            default: ptr_idx = 2'd0;
        endcase
    end

    // Scan upward from the pointer, wrapping 3->0; first set request wins.
    always_comb begin
        winner   = 4'b0000;
        win_idx  = 2'd0;
        scan_idx = 2'd0;
        found    = 1'b0;
        for (int k = 0; k < 4; k++) begin
            scan_idx = ptr_idx + 2'(k);
            if (!found && iRequest[scan_idx]) begin
                found   = 1'b1;
                win_idx = scan_idx;
                winner  = 4'b0001 << scan_idx;
            end
        end
    end

`ifdef ARB_WATCHDOG_EN
    logic [7:0] wd_count;
    logic [7:0] wd_next;
    logic       timeout_q;

    assign wd_next  = wd_count + 8'd1;
    assign expire   = (wd_next == 8'(TIMEOUT)) && !iUnitDone;
    assign oTimeout = timeout_q;

    // Counter restarts each time BUSY is entered; a done in the expiry cycle wins.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            wd_count  <= 8'd0;
            timeout_q <= 1'b0;
        end else begin
            timeout_q <= (state == BUSY) && expire;
            if (state == START) begin
                wd_count <= 8'd0;
            end else if (state == BUSY) begin
                wd_count <= wd_next;
            end
        end
    end
`else
    assign expire   = 1'b0;
    assign oTimeout = 1'b0;
`endif

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (found) state_next = START;
            START:   state_next = BUSY;
            BUSY:    if (iUnitDone || expire) state_next = RELEASE;
            RELEASE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state   <= IDLE;
            ptr     <= 4'b0001;
            grant   <= 4'b0000;
            operand <= '0;
        end else begin
            state <= state_next;
            if (state == IDLE && found) begin
                grant   <= winner;
                operand <= iOperand[win_idx*SIZE +: SIZE];
                ptr     <= {winner[2:0], winner[3]};
            end else if (state == RELEASE) begin
                grant <= 4'b0000;
            end
        end
    end

    assign oGrant       = grant;
    assign oUnitOperand = operand;
    assign oUnitStart   = (state == START);
    assign oDone        = (state == RELEASE) ? grant : 4'b0000;
    assign oBusy        = (state != IDLE);

endmodule
